// File: rtl/dsp_op_scheduler_if.sv
// Requester, DSP control and response signals of the DSP operation scheduler.
// slave: the scheduler side; master: the requesters/DSP environment side.
interface dsp_op_scheduler_if;
  logic       req0_valid;
  logic       req1_valid;
  logic       req0_ready;
  logic       req1_ready;
  logic [1:0] req0_mode;
  logic [1:0] req1_mode;
  logic       req0_mac;
  logic       req1_mac;
  logic [1:0] req0_shift;
  logic [1:0] req1_shift;
  logic       dsp_start;
  logic [1:0] dsp_mode;
  logic       dsp_mac;
  logic [1:0] dsp_barrel_shifter;
  logic       dsp_done;
  logic       rsp_valid;
  logic       rsp_id;
  logic       rsp_err;
  logic       busy;
  logic       err_flag;

  modport slave (
    input  req0_valid, req1_valid, req0_mode, req1_mode, req0_mac, req1_mac,
    input  req0_shift, req1_shift, dsp_done,
    output req0_ready, req1_ready, dsp_start, dsp_mode, dsp_mac, dsp_barrel_shifter,
    output rsp_valid, rsp_id, rsp_err, busy, err_flag
  );

  modport master (
    output req0_valid, req1_valid, req0_mode, req1_mode, req0_mac, req1_mac,
    output req0_shift, req1_shift, dsp_done,
    input  req0_ready, req1_ready, dsp_start, dsp_mode, dsp_mac, dsp_barrel_shifter,
    input  rsp_valid, rsp_id, rsp_err, busy, err_flag
  );
endinterface

// File: rtl/dsp_op_scheduler.sv
// Round-robin two-requester scheduler issuing one DSP operation per II cycles.
// Define DSP_SCHED_LATCHK_EN to check dsp_done timing and raise a sticky err_flag.
module dsp_op_scheduler #(
  parameter int unsigned II    = 4,
  parameter int unsigned LAT_W = 2
) (
  input logic               clk,
  input logic               rst,
  dsp_op_scheduler_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StGap} state_e;

  localparam logic [3:0] GapEnd = 4'(II - 1);

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [3:0]       ii_cnt_q, ii_cnt_d;
  logic [1:0]       mode_q, shift_q;
  logic             mac_q, id_q, err_q;

  logic       grant0, grant1, accept, acc_illegal;
  logic [1:0] acc_mode, acc_shift;
  logic       acc_mac;

  function automatic logic [LAT_W-1:0] lat_of(input logic [1:0] mode);
    case (mode)
      2'b01:   return LAT_W'(1);
      2'b10:   return LAT_W'(3);
      default: return '0;
    endcase
  endfunction

  // last_q holds the index of the most recent grant; the other side wins a tie.
  assign grant1 = bus_io.req1_valid & (~bus_io.req0_valid | ~last_q);
  assign grant0 = bus_io.req0_valid & ~grant1;

  assign bus_io.req0_ready = (state_q == StIdle) & ~rst & grant0;
  assign bus_io.req1_ready = (state_q == StIdle) & ~rst & grant1;
  assign accept            = bus_io.req0_ready | bus_io.req1_ready;

  assign acc_mode    = grant1 ? bus_io.req1_mode  : bus_io.req0_mode;
  assign acc_mac     = grant1 ? bus_io.req1_mac   : bus_io.req0_mac;
  assign acc_shift   = grant1 ? bus_io.req1_shift : bus_io.req0_shift;
  assign acc_illegal = (acc_mode == 2'b11);

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    lat_d    = lat_q;
    ii_cnt_d = (ii_cnt_q == 4'hf) ? ii_cnt_q : 4'(ii_cnt_q + 4'd1);
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d  = StIssue;
          last_d   = grant1;
          lat_d    = lat_of(acc_mode);
          ii_cnt_d = 4'd1;
        end
      end
      StIssue: begin
        if (err_q) begin
          state_d = StIdle;
        end else if (lat_q == '0) begin
          state_d = StGap;
        end else begin
          state_d = StWait;
          lat_d   = lat_q - LAT_W'(1);
        end
      end
      StWait: begin
        if (lat_q == '0) begin
          state_d = StGap;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      StGap: begin
        // ii_cnt_q counts cycles since the accept; IDLE is reached at T+II at the earliest.
        if (ii_cnt_q >= GapEnd) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      lat_q    <= '0;
      ii_cnt_q <= '0;
      mode_q   <= 2'b00;
      mac_q    <= 1'b0;
      shift_q  <= 2'b00;
      id_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      lat_q    <= lat_d;
      ii_cnt_q <= ii_cnt_d;
      if (accept) begin
        id_q  <= grant1;
        err_q <= acc_illegal;
        // The DSP bus keeps the last issued op; an illegal op never reaches it.
        if (!acc_illegal) begin
          mode_q  <= acc_mode;
          mac_q   <= acc_mac;
          shift_q <= acc_shift;
        end
      end
    end
  end

  assign bus_io.busy               = (state_q != StIdle);
  assign bus_io.dsp_start          = (state_q == StIssue) & ~err_q;
  assign bus_io.rsp_valid          = ((state_q == StIssue) & (err_q | (lat_q == '0))) |
                                     ((state_q == StWait) & (lat_q == '0));
  assign bus_io.rsp_id             = bus_io.rsp_valid & id_q;
  assign bus_io.rsp_err            = bus_io.rsp_valid & err_q;
  assign bus_io.dsp_mode           = mode_q;
  assign bus_io.dsp_mac            = mac_q;
  assign bus_io.dsp_barrel_shifter = shift_q;

`ifdef DSP_SCHED_LATCHK_EN
  logic err_flag_q;
  logic done_exp;

  // A legal op completes exactly when its response is produced.
  assign done_exp = bus_io.rsp_valid & ~err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_flag_q <= 1'b0;
    end else if (bus_io.dsp_done != done_exp) begin
      err_flag_q <= 1'b1;
    end
  end

  assign bus_io.err_flag = err_flag_q;
`else
  assign bus_io.err_flag = bus_io.dsp_done & 1'b0;
`endif

endmodule

// File: doc/dsp_op_scheduler.md
DSP_OP_SCHEDULER -- requirements
Module: dsp_op_scheduler

Interface
REQ-001 SHALL have parameter II, default 4, meaning the minimum number of cycles between consecutive dsp_start pulses (legal range 4..15).
REQ-002 SHALL have parameter LAT_W, default 2, meaning the width of the internal latency counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have ports req0_valid and req1_valid, input, 1 bit each: the requester has an operation pending.
REQ-006 SHALL have ports req0_ready and req1_ready, output, 1 bit each: the operation is accepted this cycle.
REQ-007 SHALL have ports req0_mode and req1_mode, input, 2 bits each: the DSP precision mode (00, 01 or 10; 11 is illegal).
REQ-008 SHALL have ports req0_mac and req1_mac, input, 1 bit each, and req0_shift and req1_shift, input, 2 bits each: the accumulate enable and the accumulator shift.
REQ-009 SHALL have outputs dsp_start (1 bit), dsp_mode (2 bits), dsp_mac (1 bit) and dsp_barrel_shifter (2 bits): the DSP control bus.
REQ-010 SHALL have port dsp_done, input, 1 bit: the DSP compare_res completion strobe.
REQ-011 SHALL have outputs rsp_valid (1 bit), rsp_id (1 bit, the requester index), rsp_err (1 bit) and busy (1 bit).
REQ-012 SHALL have port err_flag, output, 1 bit: sticky latency-check error.

Function
REQ-013 SHALL implement the FSM states IDLE, ISSUE, WAIT and GAP, and SHALL drive busy=1 in every state except IDLE.
REQ-014 SHALL assert readiness only in IDLE, combinationally and only for the granted requester; an accept is valid&ready.
REQ-015 SHALL arbitrate round-robin with a last-grant pointer; the pointer resets to 1, so requester 0 wins the first contention, and the pointer updates only on an accept.
REQ-016 SHALL, on a legal accept in cycle T, latch mode, mac, shift and id, move to ISSUE, and pulse dsp_start for exactly one cycle at T+1.
REQ-017 SHALL use mode latency L = 0, 1 or 3 for mode 00, 01 or 10 respectively, and SHALL pulse rsp_valid for one cycle at T+1+L with the latched rsp_id and rsp_err=0.
REQ-018 SHALL hold dsp_mode, dsp_mac and dsp_barrel_shifter at the latched values from T+1 until the next issue, because the DSP decodes mode during its latency.
REQ-019 SHALL transition ISSUE->WAIT when L>0 (counting down L), ISSUE->GAP when L=0, and WAIT->GAP when the count expires.
REQ-020 SHALL leave GAP for IDLE so that the next accept happens no earlier than T+II, making the next dsp_start no earlier than T+1+II.
REQ-021 SHALL consume an illegal mode 11 with no dsp_start, pulse rsp_valid with rsp_err=1 at T+1, and return to IDLE at T+2.
REQ-022 SHALL treat simultaneous req0/req1 valid as resolved by the pointer, with the loser held and not dropped.
REQ-023 SHALL ignore input changes from a requester after its accept.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, enter IDLE, clear all outputs to 0 (dsp_mode=00, err_flag=0) and set the pointer to 1.
REQ-025 SHALL, on reset mid-operation, drop the in-flight operation with no rsp_valid.
REQ-026 SHALL make rst dominate an accept in the same cycle.

Configuration
REQ-027 SHALL, when DSP_SCHED_LATCHK_EN is defined, compare dsp_done against the expected completion cycle T+1+L and set err_flag sticky on any mismatch (early, late or spurious).
REQ-028 SHALL, without DSP_SCHED_LATCHK_EN, tie err_flag to 0 and ignore dsp_done.

Verification
REQ-029 SHALL cover: req0 with mode 00 accepted at cycle 5 -> dsp_start at 6, rsp_valid at 6 with rsp_id=0, next dsp_start no earlier than 10.
REQ-030 SHALL cover: req1 with mode 10, mac=1, shift=2 accepted at 5 -> dsp_start at 6, rsp_valid at 9, and dsp_mode=10, dsp_mac=1, dsp_barrel_shifter=2 held through cycle 9.
REQ-031 SHALL cover: both requesters valid continuously, all mode 01 -> grants alternate 0,1,0,1, with dsp_start every 4 cycles at II=4.
REQ-032 SHALL cover: mode 11 from req0 -> no dsp_start, rsp_valid with rsp_err=1 one cycle after the accept.
REQ-033 SHALL cover: rst pulsed in WAIT of a mode-10 operation -> no rsp_valid, busy=0, and req0 wins the next contention.
REQ-034 SHALL cover, with DSP_SCHED_LATCHK_EN defined: dsp_done delayed by one cycle on a mode-01 operation -> err_flag=1, held until rst.
